// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants for the ID/EX stage and the execution block:
// ALU op codes, major opcodes, funct fields and the control bundle type.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [5:0] F6_BASE = 6'b000000;
    localparam logic [5:0] F6_SRA  = 6'b010000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LD   = 3'b011;
    localparam logic [2:0] F3_SD   = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    typedef enum logic [2:0] {
        ImmZero,
        ImmI,
        ImmS,
        ImmB,
        ImmShamt
    } imm_sel_e;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } ctrl_t;

    // funct3 -> ALU op for the integer ALU group; alt selects SUB/SRA.
    function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Immediate extraction: I, S, B and 6-bit shift amount, each extended to XLEN.
// Takes instr[31:20] and instr[11:7], the only fields an immediate draws on.
module id_ex_stage_imm_gen #(
    parameter int unsigned XLEN = 64
) (
    input  logic [11:0]     instr_hi_i,
    input  logic [4:0]      instr_lo_i,
    output logic [XLEN-1:0] imm_i_o,
    output logic [XLEN-1:0] imm_s_o,
    output logic [XLEN-1:0] imm_b_o,
    output logic [XLEN-1:0] imm_sh_o
);

    logic sign;
    assign sign = instr_hi_i[11];

    assign imm_i_o  = {{(XLEN-12){sign}}, instr_hi_i};
    assign imm_s_o  = {{(XLEN-12){sign}}, instr_hi_i[11:5], instr_lo_i};
    assign imm_b_o  = {{(XLEN-13){sign}}, sign, instr_lo_i[0], instr_hi_i[10:5],
                       instr_lo_i[4:1], 1'b0};
    assign imm_sh_o = {{(XLEN-6){1'b0}}, instr_hi_i[5:0]};

endmodule

// File: rtl/id_ex_stage.sv
// Decode plus ID/EX pipeline register feeding the execution block.
// Optional IDEX_PC_EN adds ifid_pc, idex_pc and idex_br_target.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifid_valid,
    input  logic [31:0]           ifid_instr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  idex_valid,
    output logic [XLEN-1:0]       idex_a,
    output logic [XLEN-1:0]       idex_b,
    output logic [XLEN-1:0]       idex_imm,
    output logic [3:0]            idex_op,
    output logic                  idex_alusrc,
    output logic                  idex_regwrite,
    output logic                  idex_memread,
    output logic                  idex_memwrite,
    output logic                  idex_memtoreg,
    output logic                  idex_branch,
    output logic [REG_ADDR_W-1:0] idex_rd,
    output logic                  idex_illegal
`ifdef IDEX_PC_EN
    ,
    input  logic [XLEN-1:0]       ifid_pc,
    output logic [XLEN-1:0]       idex_pc,
    output logic [XLEN-1:0]       idex_br_target
`endif
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;
    assign opcode = ifid_instr[6:0];
    assign f3     = ifid_instr[14:12];
    assign f7     = ifid_instr[31:25];
    assign f6     = ifid_instr[31:26];

    // rs1 index is consumed by the register file, not here.
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^ifid_instr[19:15];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_sh;

    id_ex_stage_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr_hi_i(ifid_instr[31:20]),
        .instr_lo_i(ifid_instr[11:7]),
        .imm_i_o   (imm_i),
        .imm_s_o   (imm_s),
        .imm_b_o   (imm_b),
        .imm_sh_o  (imm_sh)
    );

    logic                  dec_legal;
    logic [3:0]            dec_op;
    logic                  dec_alusrc;
    ctrl_t                 dec_ctrl;
    imm_sel_e              dec_imm_sel;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic [XLEN-1:0]       dec_imm;

    always_comb begin
        dec_legal   = 1'b0;
        dec_op      = ALU_ADD;
        dec_alusrc  = 1'b0;
        dec_ctrl    = '0;
        dec_imm_sel = ImmZero;
        dec_rd      = REG_ADDR_W'(ifid_instr[11:7]);
        case (opcode)
            OP_R: begin
                dec_legal = (f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                dec_op = alu_op_from_f3(f3, f7 == F7_ALT);
                dec_ctrl.regwrite = 1'b1;
            end
            OP_I: begin
                if (f3 == F3_SLL) begin
                    dec_legal = (f6 == F6_BASE);
                end else if (f3 == F3_SR) begin
                    dec_legal = (f6 == F6_BASE) || (f6 == F6_SRA);
                end else begin
                    dec_legal = 1'b1;
                end
                dec_op = alu_op_from_f3(f3, (f3 == F3_SR) && (f6 == F6_SRA));
                dec_alusrc = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                dec_imm_sel = ((f3 == F3_SLL) || (f3 == F3_SR)) ? ImmShamt : ImmI;
            end
            OP_LD: begin
                dec_legal         = (f3 == F3_LD);
                dec_alusrc        = 1'b1;
                dec_ctrl.memread  = 1'b1;
                dec_ctrl.memtoreg = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                dec_imm_sel       = ImmI;
            end
            OP_ST: begin
                dec_legal         = (f3 == F3_SD);
                dec_alusrc        = 1'b1;
                dec_ctrl.memwrite = 1'b1;
                dec_imm_sel       = ImmS;
                dec_rd            = '0;
            end
            OP_BR: begin
                dec_legal       = (f3 == F3_BEQ);
                dec_op          = ALU_SUB;
                dec_ctrl.branch = 1'b1;
                dec_imm_sel     = ImmB;
                dec_rd          = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        dec_imm = '0;
        unique case (dec_imm_sel)
            ImmI:     dec_imm = imm_i;
            ImmS:     dec_imm = imm_s;
            ImmB:     dec_imm = imm_b;
            ImmShamt: dec_imm = imm_sh;
            default:  dec_imm = '0;
        endcase
    end

    logic take;
    assign take = ifid_valid && dec_legal;

    logic                  valid_d, valid_q;
    logic [XLEN-1:0]       a_d, a_q;
    logic [XLEN-1:0]       b_d, b_q;
    logic [XLEN-1:0]       imm_d, imm_q;
    logic [3:0]            op_d, op_q;
    logic                  alusrc_d, alusrc_q;
    ctrl_t                 ctrl_d, ctrl_q;
    logic [REG_ADDR_W-1:0] rd_d, rd_q;
    logic                  illegal_d, illegal_q;
`ifdef IDEX_PC_EN
    logic [XLEN-1:0]       pc_d, pc_q;
    logic [XLEN-1:0]       br_target_d, br_target_q;
`endif

    // Hold by default; flush or an unstalled edge starts from a bubble.
    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        op_d      = op_q;
        alusrc_d  = alusrc_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
`ifdef IDEX_PC_EN
        pc_d        = pc_q;
        br_target_d = br_target_q;
`endif
        if (flush || !stall) begin
            valid_d   = 1'b0;
            a_d       = '0;
            b_d       = '0;
            imm_d     = '0;
            op_d      = ALU_ADD;
            alusrc_d  = 1'b0;
            ctrl_d    = '0;
            rd_d      = '0;
            illegal_d = !flush && ifid_valid && !dec_legal;
`ifdef IDEX_PC_EN
            pc_d        = '0;
            br_target_d = '0;
`endif
            if (!flush && take) begin
                valid_d  = 1'b1;
                a_d      = rs1_data;
                b_d      = rs2_data;
                imm_d    = dec_imm;
                op_d     = dec_op;
                alusrc_d = dec_alusrc;
                ctrl_d   = dec_ctrl;
                rd_d     = dec_rd;
`ifdef IDEX_PC_EN
                pc_d        = ifid_pc;
                br_target_d = ifid_pc + imm_b;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            op_q      <= ALU_ADD;
            alusrc_q  <= 1'b0;
            ctrl_q    <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
`ifdef IDEX_PC_EN
            pc_q        <= '0;
            br_target_q <= '0;
`endif
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            op_q      <= op_d;
            alusrc_q  <= alusrc_d;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
`ifdef IDEX_PC_EN
            pc_q        <= pc_d;
            br_target_q <= br_target_d;
`endif
        end
    end

    assign idex_valid    = valid_q;
    assign idex_a        = a_q;
    assign idex_b        = b_q;
    assign idex_imm      = imm_q;
    assign idex_op       = op_q;
    assign idex_alusrc   = alusrc_q;
    assign idex_regwrite = ctrl_q.regwrite;
    assign idex_memread  = ctrl_q.memread;
    assign idex_memwrite = ctrl_q.memwrite;
    assign idex_memtoreg = ctrl_q.memtoreg;
    assign idex_branch   = ctrl_q.branch;
    assign idex_rd       = rd_q;
    assign idex_illegal  = illegal_q;
`ifdef IDEX_PC_EN
    assign idex_pc        = pc_q;
    assign idex_br_target = br_target_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each vector pushes its expected ID/EX
// contents, which are popped and compared one cycle later.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [63:0] rs1_data, rs2_data;
    logic        stall, flush;
    logic        idex_valid;
    logic [63:0] idex_a, idex_b, idex_imm;
    logic [3:0]  idex_op;
    logic        idex_alusrc, idex_regwrite, idex_memread, idex_memwrite;
    logic        idex_memtoreg, idex_branch;
    logic [4:0]  idex_rd;
    logic        idex_illegal;
`ifdef IDEX_PC_EN
    logic [63:0] ifid_pc = '0;
    logic [63:0] idex_pc, idex_br_target;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(
        .XLEN      (64),
        .REG_ADDR_W(5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .stall        (stall),
        .flush        (flush),
        .idex_valid   (idex_valid),
        .idex_a       (idex_a),
        .idex_b       (idex_b),
        .idex_imm     (idex_imm),
        .idex_op      (idex_op),
        .idex_alusrc  (idex_alusrc),
        .idex_regwrite(idex_regwrite),
        .idex_memread (idex_memread),
        .idex_memwrite(idex_memwrite),
        .idex_memtoreg(idex_memtoreg),
        .idex_branch  (idex_branch),
        .idex_rd      (idex_rd),
        .idex_illegal (idex_illegal)
`ifdef IDEX_PC_EN
        ,
        .ifid_pc       (ifid_pc),
        .idex_pc       (idex_pc),
        .idex_br_target(idex_br_target)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic [3:0]  op;
        logic        alusrc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mtr;
        logic        br;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        v;
        logic        st;
        logic        fl;
        logic [31:0] ins;
        logic [63:0] r1;
        logic [63:0] r2;
        exp_t        e;
    } vec_t;

    exp_t obs;
    assign obs = {idex_valid, idex_a, idex_b, idex_imm, idex_op, idex_alusrc, idex_regwrite,
                  idex_memread, idex_memwrite, idex_memtoreg, idex_branch, idex_rd,
                  idex_illegal};

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam exp_t BUBBLE = '0;

    function automatic exp_t mk(input logic v, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] imm, input logic [3:0] op,
                                input logic alusrc, input logic rw, input logic mr,
                                input logic mw, input logic mtr, input logic br,
                                input logic [4:0] rd, input logic ill);
        exp_t e;
        e = '{valid: v, a: a, b: b, imm: imm, op: op, alusrc: alusrc, rw: rw, mr: mr,
              mw: mw, mtr: mtr, br: br, rd: rd, ill: ill};
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic vec_t vec(input logic rst, input logic v, input logic st,
                                 input logic fl, input logic [31:0] ins,
                                 input logic [63:0] r1, input logic [63:0] r2,
                                 input exp_t e);
        vec_t x;
        x.rst = rst; x.v = v; x.st = st; x.fl = fl;
        x.ins = ins; x.r1 = r1; x.r2 = r2; x.e = e;
        return x;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive(input vec_t x);
        reset      = x.rst;
        ifid_valid = x.v;
        ifid_instr = x.ins;
        rs1_data   = x.r1;
        rs2_data   = x.r2;
        stall      = x.st;
        flush      = x.fl;
        sb.push_back(x.e);
    endtask

    task automatic test_reset();
        exp_t e;
        drive(vec(1, 1, 0, 0, 32'h002081B3, 64'd5, 64'd7, BUBBLE));
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset got %h exp %h", obs, e);
        end
    endtask

    task automatic test_r_type();
        vec_t        q[$];
        logic [63:0] x, y;
        exp_t        e;
        q.push_back(vec(0, 1, 0, 0, 32'h002081B3, 64'd5, 64'd7,
                        mk(1, 64'd5, 64'd7, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 5'd3, 0)));
        q.push_back(vec(0, 1, 0, 0, 32'h407302B3, 64'd100, 64'd30,
                        mk(1, 64'd100, 64'd30, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 5'd5, 0)));
        x = rnd64(); y = rnd64();
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd10), x, y,
                        mk(1, x, y, 0, 4'b0010, 0, 1, 0, 0, 0, 0, 5'd10, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd11), y, x,
                        mk(1, y, x, 0, 4'b0011, 0, 1, 0, 0, 0, 0, 5'd11, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd12), x, x,
                        mk(1, x, x, 0, 4'b0100, 0, 1, 0, 0, 0, 0, 5'd12, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd13), x, y,
                        mk(1, x, y, 0, 4'b0101, 0, 1, 0, 0, 0, 0, 5'd13, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd14), x, y,
                        mk(1, x, y, 0, 4'b0110, 0, 1, 0, 0, 0, 0, 5'd14, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd15), x, y,
                        mk(1, x, y, 0, 4'b0111, 0, 1, 0, 0, 0, 0, 5'd15, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd16), x, y,
                        mk(1, x, y, 0, 4'b1000, 0, 1, 0, 0, 0, 0, 5'd16, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd17), x, y,
                        mk(1, x, y, 0, 4'b1001, 0, 1, 0, 0, 0, 0, 5'd17, 0)));
        // rd = x0 still carries regwrite
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), y, y,
                        mk(1, y, y, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 5'd0, 0)));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL r_type[%0d] got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_i_type();
        vec_t        q[$];
        logic [63:0] x, y;
        exp_t        e;
        x = rnd64(); y = rnd64();
        q.push_back(vec(0, 1, 0, 0, 32'hFFB00093, 64'd0, y,
                        mk(1, 64'd0, y, 64'hFFFF_FFFF_FFFF_FFFB, 4'b0000, 1, 1, 0, 0, 0, 0,
                           5'd1, 0)));
        q.push_back(vec(0, 1, 0, 0, 32'h40335313, x, y,
                        mk(1, x, y, 64'd3, 4'b0111, 1, 1, 0, 0, 0, 0, 5'd6, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_i(12'd33, 5'd3, 3'b001, 5'd2), x, y,
                        mk(1, x, y, 64'd33, 4'b0110, 1, 1, 0, 0, 0, 0, 5'd2, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_i(12'd63, 5'd3, 3'b101, 5'd2), x, y,
                        mk(1, x, y, 64'd63, 4'b0101, 1, 1, 0, 0, 0, 0, 5'd2, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_i(12'hFFF, 5'd4, 3'b010, 5'd8), x, y,
                        mk(1, x, y, '1, 4'b1000, 1, 1, 0, 0, 0, 0, 5'd8, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_i(12'h7FF, 5'd4, 3'b011, 5'd9), x, y,
                        mk(1, x, y, 64'h7FF, 4'b1001, 1, 1, 0, 0, 0, 0, 5'd9, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_i(12'h800, 5'd4, 3'b111, 5'd20), x, y,
                        mk(1, x, y, 64'hFFFF_FFFF_FFFF_F800, 4'b0010, 1, 1, 0, 0, 0, 0,
                           5'd20, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_i(12'h123, 5'd4, 3'b110, 5'd21), x, y,
                        mk(1, x, y, 64'h123, 4'b0011, 1, 1, 0, 0, 0, 0, 5'd21, 0)));
        q.push_back(vec(0, 1, 0, 0, enc_i(12'h0F0, 5'd4, 3'b100, 5'd31), x, y,
                        mk(1, x, y, 64'h0F0, 4'b0100, 1, 1, 0, 0, 0, 0, 5'd31, 0)));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL i_type[%0d] got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_mem_branch();
        vec_t        q[$];
        logic [63:0] x, y;
        exp_t        e;
        x = rnd64(); y = rnd64();
        q.push_back(vec(0, 1, 0, 0, 32'h01013203, x, y,
                        mk(1, x, y, 64'd16, 4'b0000, 1, 1, 1, 0, 1, 0, 5'd4, 0)));
        q.push_back(vec(0, 1, 0, 0, 32'h00513423, x, y,
                        mk(1, x, y, 64'd8, 4'b0000, 1, 0, 0, 1, 0, 0, 5'd0, 0)));
        q.push_back(vec(0, 1, 0, 0, 32'hFE313823, y, x,
                        mk(1, y, x, 64'hFFFF_FFFF_FFFF_FFF0, 4'b0000, 1, 0, 0, 1, 0, 0,
                           5'd0, 0)));
        q.push_back(vec(0, 1, 0, 0, 32'hFE208CE3, x, y,
                        mk(1, x, y, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0001, 0, 0, 0, 0, 0, 1,
                           5'd0, 0)));
        q.push_back(vec(0, 1, 0, 0, 32'h002080E3, y, y,
                        mk(1, y, y, 64'h800, 4'b0001, 0, 0, 0, 0, 0, 1, 5'd0, 0)));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mem_branch[%0d] got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_illegal();
        vec_t q[$];
        exp_t ill;
        exp_t e;
        ill = BUBBLE;
        ill.ill = 1'b1;
        q.push_back(vec(0, 1, 0, 0, 32'hFFFFFFFF, 64'd1, 64'd2, ill));
        q.push_back(vec(0, 0, 0, 0, 32'h002081B3, 64'd1, 64'd2, BUBBLE));
        q.push_back(vec(0, 1, 0, 0, 32'h01012203, 64'd1, 64'd2, ill));
        q.push_back(vec(0, 1, 0, 0, enc_r(7'h20, 5'd2, 5'd1, 3'b001, 5'd3), 64'd1, 64'd2, ill));
        q.push_back(vec(0, 1, 0, 0, enc_i({6'b010000, 6'd1}, 5'd1, 3'b001, 5'd2), 64'd1,
                        64'd2, ill));
        q.push_back(vec(0, 1, 0, 0, 32'hFE209CE3, 64'd1, 64'd2, ill));
        q.push_back(vec(0, 0, 0, 0, 32'hFFFFFFFF, 64'd1, 64'd2, BUBBLE));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL illegal[%0d] got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_stall_flush();
        vec_t q[$];
        exp_t add_e, ill;
        exp_t e;
        add_e = mk(1, 64'd5, 64'd7, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 5'd3, 0);
        ill = BUBBLE;
        ill.ill = 1'b1;
        q.push_back(vec(0, 1, 0, 0, 32'h002081B3, 64'd5, 64'd7, add_e));
        for (int k = 0; k < 3; k++) begin
            q.push_back(vec(0, 1, 1, 0, 32'h407302B3, 64'd9, 64'd11, add_e));
        end
        q.push_back(vec(0, 1, 1, 1, 32'h407302B3, 64'd9, 64'd11, BUBBLE));
        q.push_back(vec(0, 1, 0, 0, 32'hFFFFFFFF, 64'd9, 64'd11, ill));
        q.push_back(vec(0, 1, 1, 0, 32'h002081B3, 64'd5, 64'd7, ill));
        q.push_back(vec(0, 1, 0, 1, 32'h002081B3, 64'd5, 64'd7, BUBBLE));
        q.push_back(vec(0, 1, 0, 0, 32'h002081B3, 64'd5, 64'd7, add_e));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL stall_flush[%0d] got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t q[$];
        exp_t e;
        q.push_back(vec(0, 1, 0, 0, 32'h01013203, 64'd40, 64'd50,
                        mk(1, 64'd40, 64'd50, 64'd16, 4'b0000, 1, 1, 1, 0, 1, 0, 5'd4, 0)));
        q.push_back(vec(1, 1, 1, 0, 32'h002081B3, 64'd5, 64'd7, BUBBLE));
        q.push_back(vec(0, 0, 0, 0, 32'h002081B3, 64'd5, 64'd7, BUBBLE));
        foreach (q[i]) begin
            drive(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d] got %h exp %h", i, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_mem_branch();
        test_illegal();
        test_stall_flush();
        test_reset_mid();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
